// File: rtl/data_mem_responder.sv
// Byte-addressed big-endian data memory with a mov/mfc handshake.
// Fixed-latency access; flags misaligned or illegal-size requests.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 9,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mov,
  input  logic                  rw,
  input  logic [1:0]            size,
  input  logic                  sign,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  mfc,
  output logic                  err
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic                  rw_q;
  logic [1:0]            size_q;
  logic                  sign_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           dout_q;
  logic                  mfc_q;
  logic                  err_q;

  logic [7:0] mem_q [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] a1, a2, a3;
  logic [7:0]            b0, b1, b2, b3;
  logic                  acc_ok;
  logic                  commit;
  logic                  we;
  logic [31:0]           ld_d;

  assign a1 = addr_q + ADDR_WIDTH'(1);
  assign a2 = addr_q + ADDR_WIDTH'(2);
  assign a3 = addr_q + ADDR_WIDTH'(3);

  assign b0 = mem_q[addr_q];
  assign b1 = mem_q[a1];
  assign b2 = mem_q[a2];
  assign b3 = mem_q[a3];

  always_comb begin
    acc_ok = 1'b0;
    unique case (size_q)
      2'b00:   acc_ok = 1'b1;
      2'b01:   acc_ok = ~addr_q[0];
      2'b10:   acc_ok = (addr_q[1:0] == 2'b00);
      default: acc_ok = 1'b0;
    endcase
  end

  // mem[a] is the most significant byte of the loaded value
  always_comb begin
    ld_d = '0;
    unique case (size_q)
      2'b00:   ld_d = {{24{sign_q & b0[7]}}, b0};
      2'b01:   ld_d = {{16{sign_q & b0[7]}}, b0, b1};
      2'b10:   ld_d = {b0, b1, b2, b3};
      default: ld_d = '0;
    endcase
  end

  assign commit = (state_q == BUSY) && (cnt_q == '0) && !reset;
  assign we     = commit && acc_ok && !rw_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mfc_q   <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mov) begin
            rw_q    <= rw;
            size_q  <= size;
            sign_q  <= sign;
            addr_q  <= addr;
            wdata_q <= data_in;
            cnt_q   <= CW'(LATENCY - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            state_q <= DONE;
            mfc_q   <= 1'b1;
            err_q   <= !acc_ok;
            if (!acc_ok)
              dout_q <= '0;
            else if (rw_q)
              dout_q <= ld_d;
          end
        end
        DONE: begin
          if (!mov) begin
            state_q <= IDLE;
            mfc_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      unique case (size_q)
        2'b00: mem_q[addr_q] <= wdata_q[7:0];
        2'b01: begin
          mem_q[addr_q] <= wdata_q[15:8];
          mem_q[a1]     <= wdata_q[7:0];
        end
        default: begin
          mem_q[addr_q] <= wdata_q[31:24];
          mem_q[a1]     <= wdata_q[23:16];
          mem_q[a2]     <= wdata_q[15:8];
          mem_q[a3]     <= wdata_q[7:0];
        end
      endcase
    end
  end

  assign data_out = dout_q;
  assign mfc      = mfc_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder.
// Driver queues expected responses; a monitor checks each mfc rise.
module tb_data_mem_responder;

  localparam int AW  = 9;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          mov;
  logic          rw;
  logic [1:0]    size;
  logic          sign;
  logic [AW-1:0] addr;
  logic [31:0]   data_in;
  logic [31:0]   data_out;
  logic          mfc;
  logic          err;

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .mov      (mov),
    .rw       (rw),
    .size     (size),
    .sign     (sign),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .mfc      (mfc),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  logic mfc_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mfc === 1'b1 && mfc_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_mfc", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("data_out", data_out, e.d);
        chk("err", {31'b0, err}, {31'b0, e.e});
      end
    end
    mfc_prev = mfc;
  end

  // Issue one request, hold mov for 'hold' cycles after mfc, then drop it.
  task automatic req(input logic r, input logic [1:0] sz, input logic sg,
                     input logic [AW-1:0] a, input logic [31:0] din,
                     input logic [31:0] exp_d, input logic exp_e,
                     input int hold, input bit nosync);
    exp_t e;
    int   n;
    bit   seen;
    e.d = exp_d;
    e.e = exp_e;
    sb.push_back(e);
    if (!nosync) @(negedge clk);
    mov = 1'b1; rw = r; size = sz; sign = sg; addr = a; data_in = din;
    seen = 0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (mfc === 1'b1) seen = 1;
    end
    if (!seen) chk("mfc_timeout", 32'd0, 32'd1);
    else chk("latency", 32'(n), 32'(LAT + 1));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("mfc_hold", {31'b0, mfc}, 32'd1);
    end
    mov = 1'b0;
    @(negedge clk);
    chk("mfc_drop", {31'b0, mfc}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; mov = 1'b0; rw = 1'b0; size = 2'b00;
    sign = 1'b0; addr = '0; data_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_mfc", {31'b0, mfc}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_dout", data_out, 32'd0);

    // word store/load
    req(0, 2'b10, 0, 9'h010, 32'hDEADBEEF, 32'h0, 0, 0, 0);
    req(1, 2'b10, 0, 9'h010, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    // byte and halfword loads
    req(1, 2'b00, 1, 9'h011, 32'h0, 32'hFFFFFFAD, 0, 0, 0);
    req(1, 2'b00, 0, 9'h011, 32'h0, 32'h000000AD, 0, 0, 0);
    req(1, 2'b01, 1, 9'h012, 32'h0, 32'hFFFFBEEF, 0, 0, 0);
    req(1, 2'b01, 0, 9'h012, 32'h0, 32'h0000BEEF, 0, 0, 0);
    // partial stores leave data_out as is
    req(0, 2'b00, 0, 9'h013, 32'h00000012, 32'h0000BEEF, 0, 0, 0);
    req(0, 2'b01, 0, 9'h010, 32'h99995566, 32'h0000BEEF, 0, 0, 0);
    req(1, 2'b10, 0, 9'h010, 32'h0, 32'h5566BE12, 0, 0, 0);
    // misaligned and illegal
    req(0, 2'b10, 0, 9'h012, 32'hFFFFFFFF, 32'h0, 1, 0, 0);
    req(1, 2'b10, 0, 9'h010, 32'h0, 32'h5566BE12, 0, 0, 0);
    req(1, 2'b01, 0, 9'h011, 32'h0, 32'h0, 1, 0, 0);
    req(1, 2'b10, 0, 9'h010, 32'h0, 32'h5566BE12, 0, 0, 0);
    req(1, 2'b11, 0, 9'h010, 32'h0, 32'h0, 1, 0, 0);

    // reset during BUSY aborts the store
    @(negedge clk);
    mov = 1'b1; rw = 1'b0; size = 2'b10; addr = 9'h010;
    data_in = 32'h11111111;
    @(negedge clk);
    chk("busy_mfc", {31'b0, mfc}, 32'd0);
    reset = 1'b1; mov = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_mfc", {31'b0, mfc}, 32'd0);
    chk("abort_err", {31'b0, err}, 32'd0);
    chk("abort_dout", data_out, 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_mfc2", {31'b0, mfc}, 32'd0);
    req(1, 2'b10, 0, 9'h010, 32'h0, 32'h5566BE12, 0, 0, 0);

    // held handshake; next request issued right after mfc drops
    req(0, 2'b00, 0, 9'h010, 32'hABCDEF77, 32'h5566BE12, 0, 5, 0);
    req(1, 2'b10, 0, 9'h010, 32'h0, 32'h7766BE12, 0, 5, 1);
    req(1, 2'b00, 1, 9'h010, 32'h0, 32'h00000077, 0, 0, 1);
    req(1, 2'b01, 1, 9'h010, 32'h0, 32'h00007766, 0, 0, 0);
    req(1, 2'b00, 1, 9'h012, 32'h0, 32'hFFFFFFBE, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_mis);
    $finish;
  end

endmodule
